// File: rtl/melee_attack_ctl.sv
// melee_attack_ctl: melee swing sequencer for the weapon sprite drawer.
// A left-button press while gameplay runs starts a swing. The offset steps out
// once per video frame, then steps back, then a cooldown runs before the next
// swing is accepted. All outputs are registered.
//
// Optional feature: define MELEE_HOLD_REPEAT_EN to auto-fire while the button
// is held. The next swing then starts on the tick that ends cooldown.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   mouse_left     left button level, already in clk domain
//   vsync          VGA vsync; each rising edge is one frame tick
//   game_active    non-zero while gameplay runs
//   facing_left    player facing direction
//   attack_active  high in SWING_OUT and SWING_BACK
//   anim_x_offset  unsigned swing offset in pixels
//   flip_hor_melee facing latched at swing start
//   hit_strobe     one-cycle pulse at full extension
//   busy           high whenever the FSM is not IDLE
module melee_attack_ctl #(
  parameter int unsigned SWING_FRAMES    = 8,
  parameter int unsigned STEP_PX         = 4,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic        vsync,
  input  logic [1:0]  game_active,
  input  logic        facing_left,
  output logic        attack_active,
  output logic [11:0] anim_x_offset,
  output logic        flip_hor_melee,
  output logic        hit_strobe,
  output logic        busy
);

  localparam int unsigned OFF_W   = 12;
  localparam int unsigned CNT_MAX = (SWING_FRAMES > COOLDOWN_FRAMES) ? SWING_FRAMES
                                                                      : COOLDOWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [OFF_W-1:0] STEP       = OFF_W'(STEP_PX);
  localparam logic [CNT_W-1:0] SWING_LAST = CNT_W'(SWING_FRAMES);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWING_OUT  = 2'd1,
    SWING_BACK = 2'd2,
    COOLDOWN   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] fcnt;
  logic             btn_q;
  logic             vs_q;

  logic             press_c;
  logic             tick_c;
  logic             run_c;
  logic [CNT_W-1:0] fcnt_inc_c;

  // Edge detection and shared increment.
  always_comb begin
    press_c    = mouse_left & ~btn_q;
    tick_c     = vsync & ~vs_q;
    run_c      = |game_active;
    fcnt_inc_c = fcnt + CNT_W'(1);
  end

  // Swing sequencer; a stopped game overrides every state, including ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      fcnt           <= '0;
      btn_q          <= 1'b0;
      vs_q           <= 1'b0;
      attack_active  <= 1'b0;
      anim_x_offset  <= '0;
      flip_hor_melee <= 1'b0;
      hit_strobe     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      btn_q      <= mouse_left;
      vs_q       <= vsync;
      hit_strobe <= 1'b0;

      if (!run_c) begin
        state          <= IDLE;
        fcnt           <= '0;
        attack_active  <= 1'b0;
        anim_x_offset  <= '0;
        flip_hor_melee <= 1'b0;
        busy           <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // A tick coinciding with the press is deliberately not counted.
            if (press_c) begin
              state          <= SWING_OUT;
              fcnt           <= '0;
              anim_x_offset  <= '0;
              flip_hor_melee <= facing_left;
              attack_active  <= 1'b1;
              busy           <= 1'b1;
            end
          end

          SWING_OUT: begin
            if (tick_c) begin
              anim_x_offset <= anim_x_offset + STEP;
              if (fcnt_inc_c == SWING_LAST) begin
                state      <= SWING_BACK;
                fcnt       <= '0;
                hit_strobe <= 1'b1;
              end else begin
                fcnt <= fcnt_inc_c;
              end
            end
          end

          SWING_BACK: begin
            // Clamp at zero so the offset can never wrap below 0.
            if (tick_c) begin
              if (anim_x_offset <= STEP) begin
                anim_x_offset <= '0;
                state         <= COOLDOWN;
                fcnt          <= '0;
                attack_active <= 1'b0;
              end else begin
                anim_x_offset <= anim_x_offset - STEP;
              end
            end
          end

          COOLDOWN: begin
            if (tick_c) begin
              if (fcnt_inc_c == COOL_LAST) begin
`ifdef MELEE_HOLD_REPEAT_EN
                // Held button re-arms straight into a new swing.
                if (mouse_left) begin
                  state          <= SWING_OUT;
                  fcnt           <= '0;
                  anim_x_offset  <= '0;
                  flip_hor_melee <= facing_left;
                  attack_active  <= 1'b1;
                  busy           <= 1'b1;
                end else begin
                  state          <= IDLE;
                  fcnt           <= '0;
                  flip_hor_melee <= 1'b0;
                  busy           <= 1'b0;
                end
`else
                state          <= IDLE;
                fcnt           <= '0;
                flip_hor_melee <= 1'b0;
                busy           <= 1'b0;
`endif
              end else begin
                fcnt <= fcnt_inc_c;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melee_attack_ctl.sv
// Directed bench for melee_attack_ctl with default parameters.
module tb_melee_attack_ctl;

  logic        clk;
  logic        rst;
  logic        mouse_left;
  logic        vsync;
  logic [1:0]  game_active;
  logic        facing_left;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic        flip_hor_melee;
  logic        hit_strobe;
  logic        busy;

  int n_vec;
  int n_err;
  int hits;
  int h0;

  melee_attack_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .mouse_left     (mouse_left),
    .vsync          (vsync),
    .game_active    (game_active),
    .facing_left    (facing_left),
    .attack_active  (attack_active),
    .anim_x_offset  (anim_x_offset),
    .flip_hor_melee (flip_hor_melee),
    .hit_strobe     (hit_strobe),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of strobe cycles, sampled just after each edge.
  initial hits = 0;
  always @(posedge clk) begin
    #1;
    if (hit_strobe) hits = hits + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One vsync rising edge, then vsync low again.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_pulse();
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b0;
    mouse_left  = 1'b0;
    vsync       = 1'b0;
    game_active = 2'd1;
    facing_left = 1'b0;
    cyc(2);
    check("rst_attack", 32'(attack_active), 32'd0);
    check("rst_offset", 32'(anim_x_offset), 32'd0);
    check("rst_busy",   32'(busy),          32'd0);
    check("rst_strobe", 32'(hit_strobe),    32'd0);
    check("rst_flip",   32'(flip_hor_melee), 32'd0);
    rst = 1'b1;
    cyc(2);

    // Nominal swing.
    h0 = hits;
    mouse_left = 1'b1;
    @(negedge clk);
    check("nom_press_attack", 32'(attack_active), 32'd1);
    check("nom_press_offset", 32'(anim_x_offset), 32'd0);
    check("nom_press_busy",   32'(busy),          32'd1);
    mouse_left = 1'b0;
    @(negedge clk);
    ticks(7);
    check("nom_t7_offset", 32'(anim_x_offset), 32'd28);
    check("nom_t7_strobe", 32'(hit_strobe),    32'd0);
    vsync = 1'b1;
    @(negedge clk);
    check("nom_t8_offset", 32'(anim_x_offset), 32'd32);
    check("nom_t8_strobe", 32'(hit_strobe),    32'd1);
    check("nom_t8_attack", 32'(attack_active), 32'd1);
    vsync = 1'b0;
    @(negedge clk);
    check("nom_strobe_low", 32'(hit_strobe), 32'd0);
    ticks(7);
    check("nom_b7_offset", 32'(anim_x_offset), 32'd4);
    check("nom_b7_attack", 32'(attack_active), 32'd1);
    ticks(1);
    check("nom_b8_offset", 32'(anim_x_offset), 32'd0);
    check("nom_b8_attack", 32'(attack_active), 32'd0);
    check("nom_b8_busy",   32'(busy),          32'd1);
    ticks(9);
    check("nom_c9_busy", 32'(busy), 32'd1);
    ticks(1);
    check("nom_c10_busy", 32'(busy), 32'd0);
    check("nom_hit_count", 32'(hits - h0), 32'd1);

    // Dropped presses during SWING_BACK and COOLDOWN.
    press_pulse();
    ticks(8);
    ticks(3);
    press_pulse();
    check("drop_back_offset", 32'(anim_x_offset), 32'd20);
    check("drop_back_attack", 32'(attack_active), 32'd1);
    ticks(5);
    check("drop_back_done", 32'(anim_x_offset), 32'd0);
    ticks(4);
    press_pulse();
    check("drop_cool_attack", 32'(attack_active), 32'd0);
    ticks(5);
    check("drop_c9_busy", 32'(busy), 32'd1);
    ticks(1);
    check("drop_c10_busy", 32'(busy), 32'd0);
    cyc(3);
    check("drop_not_queued", 32'(attack_active), 32'd0);

    // Facing latch.
    facing_left = 1'b1;
    press_pulse();
    check("face_latch", 32'(flip_hor_melee), 32'd1);
    ticks(2);
    facing_left = 1'b0;
    ticks(14);
    check("face_hold_back", 32'(flip_hor_melee), 32'd1);
    ticks(9);
    check("face_hold_cool", 32'(flip_hor_melee), 32'd1);
    ticks(1);
    check("face_idle_busy", 32'(busy), 32'd0);

    // Game stop mid-swing.
    h0 = hits;
    press_pulse();
    ticks(5);
    check("stop_t5_offset", 32'(anim_x_offset), 32'd20);
    game_active = 2'd0;
    @(negedge clk);
    check("stop_offset", 32'(anim_x_offset), 32'd0);
    check("stop_attack", 32'(attack_active), 32'd0);
    check("stop_busy",   32'(busy),          32'd0);
    ticks(4);
    press_pulse();
    check("stop_press_attack", 32'(attack_active), 32'd0);
    check("stop_press_busy",   32'(busy),          32'd0);
    check("stop_no_strobe",    32'(hits - h0),     32'd0);
    game_active = 2'd2;
    cyc(2);

    // Asynchronous reset mid-swing.
    press_pulse();
    ticks(4);
    check("rst_mid_offset", 32'(anim_x_offset), 32'd16);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_offset", 32'(anim_x_offset), 32'd0);
    check("rst_async_attack", 32'(attack_active), 32'd0);
    check("rst_async_busy",   32'(busy),          32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mouse_left = 1'b1;
    @(negedge clk);
    check("rst_new_attack", 32'(attack_active), 32'd1);
    check("rst_new_offset", 32'(anim_x_offset), 32'd0);
    mouse_left = 1'b0;
    @(negedge clk);
    ticks(1);
    check("rst_new_t1", 32'(anim_x_offset), 32'd4);
    ticks(25);
    check("rst_new_done", 32'(busy), 32'd0);

    // Held button through a full swing.
    mouse_left = 1'b1;
    @(negedge clk);
    check("hold_start", 32'(attack_active), 32'd1);
    ticks(25);
    check("hold_c9_busy", 32'(busy), 32'd1);
    ticks(1);
`ifdef MELEE_HOLD_REPEAT_EN
    check("hold_repeat_attack", 32'(attack_active), 32'd1);
    check("hold_repeat_offset", 32'(anim_x_offset), 32'd0);
    mouse_left = 1'b0;
    ticks(1);
    check("hold_repeat_t1", 32'(anim_x_offset), 32'd4);
    ticks(25);
    check("hold_repeat_done", 32'(busy), 32'd0);
`else
    check("hold_idle_busy", 32'(busy), 32'd0);
    ticks(2);
    check("hold_no_retrigger", 32'(attack_active), 32'd0);
    mouse_left = 1'b0;
    @(negedge clk);
    mouse_left = 1'b1;
    @(negedge clk);
    check("hold_repress", 32'(attack_active), 32'd1);
    mouse_left = 1'b0;
    ticks(26);
    check("hold_repress_done", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
